mem_io_responder: RTL and testbench
===================================

// Module: mem_io_responder
// PURPOSE
//   Memory/IO responder for the cpu byte bus (mem_a/mem_dout/mem_wr in, mem_din/io_buffer_full out).
//   Holds 128KB byte RAM plus IO hub: UART TX FIFO, UART RX FIFO, cycle counter, program-stop flag.
//   Sits outside cpu; used in simulation top and FPGA top as cpu's single bus target.
// PARAMETERS
//   ADDR_WIDTH     17  RAM byte-address width (2^17 = 128KB)
//   TX_FIFO_DEPTH  8   UART TX FIFO entries, power of 2, >=4
//   RX_FIFO_DEPTH  8   UART RX FIFO entries, power of 2, >=2
// PORTS
//   clk_in          in   1   clock
//   rst_in          in   1   synchronous active-high reset
//   mem_a           in   32  cpu address; only [17:0] decoded
//   mem_dout        in   8   cpu write data
//   mem_wr          in   1   1 = write, 0 = read
//   mem_din         out  8   read data to cpu, registered
//   io_buffer_full  out  1   TX FIFO nearly full; cpu must not write 0x30000
//   uart_tx_valid   out  1   TX FIFO head valid
//   uart_tx_data    out  8   TX FIFO head byte
//   uart_tx_ready   in   1   UART accepts head this cycle
//   uart_rx_valid   in   1   UART delivers received byte this cycle
//   uart_rx_data    in   8   received byte
//   program_stop    out  1   sticky; set by write to 0x30004
//   tx_overflow     out  1   sticky; TX push dropped because FIFO full
// BEHAVIOUR
//   Decode: io = (mem_a[17:16]==2'b11); else RAM at mem_a[ADDR_WIDTH-1:0] (higher bits ignored).
//   RAM write: mem_wr & !io -> ram[a] <= mem_dout at this edge.
//   Reads: mem_wr=0 every cycle is a read; mem_din updates at the next edge (1-cycle latency).
//     Read-after-write to same address in consecutive cycles returns the new byte.
//   IO read 0x30000: pops RX FIFO, returns head; RX empty -> 0x00, no pop.
//   IO read 0x30004..0x30007: byte k of 32-bit snapshot (little-endian).
//     Read of 0x30004 returns cycle_cnt[7:0] and latches snapshot <= cycle_cnt; 0x30005-7 return snapshot[15:8]/[23:16]/[31:24].
//   cycle_cnt: 32-bit, +1 every cycle after reset, wraps 0xFFFFFFFF -> 0.
//   IO write 0x30000: data != 0 -> push TX FIFO; data == 0 -> ignored.
//   IO write 0x30004: program_stop <= 1; pushes 0x00 into TX FIFO.
//   Other IO addresses: reads return 0x00 with no side effect, writes ignored.
//   TX FIFO: uart_tx_valid = !empty; pop on uart_tx_valid & uart_tx_ready.
//     Push accepted if not full OR pop in same cycle; else byte dropped, tx_overflow <= 1.
//     io_buffer_full = (tx_count >= TX_FIFO_DEPTH-1), driven from registered count (1 slot slack for cpu lag).
//   RX FIFO: push on uart_rx_valid; full -> byte dropped (unless cpu pops same cycle, then accepted).
//     Simultaneous push and pop on empty FIFO: read returns 0x00, pushed byte retained.
//   Pointers: log2(depth)+1 bits, wrap naturally; full = MSB differs, rest equal.
//   Reset: both FIFOs empty, cycle_cnt=0, snapshot=0, mem_din=0x00, io_buffer_full=0,
//     uart_tx_valid=0, program_stop=0, tx_overflow=0. RAM contents not cleared (preload via $readmemh).
//   Reset mid-operation: in-flight read discarded (mem_din=0x00 next cycle), queued UART bytes lost.
// TESTING
//   1. Write 0xA5 @0x00010, read 0x00010 next cycle -> mem_din=0xA5 one cycle after read address.
//   2. Writes 'H','i',0x00 to 0x30000, uart_tx_ready=1 -> uart_tx_data 0x48 then 0x69; 0x00 never enqueued.
//   3. uart_tx_ready=0, 7 writes to 0x30000 (depth 8) -> io_buffer_full=1 after 7th; 9th write -> tx_overflow=1, FIFO holds 8.
//   4. After reset, read 0x30004..0x30007 at cycle N -> bytes assemble to N exactly, no tearing across [7:0] carry.
//   5. uart_rx_valid with 0x31 then read 0x30000 twice -> mem_din 0x31 then 0x00.
//   6. Write 0x30004 -> program_stop=1, 0x00 emitted on uart_tx_data; rst_in -> program_stop=0, FIFOs empty.

Source files
------------

// File: rtl/mem_io_responder_if.sv
// CPU byte-bus bundle between the cpu (master) and its single memory/IO target (slave).
// Carries address, write data and strobe outward, and read data plus TX back-pressure inward.
interface mem_io_responder_if;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic        io_buffer_full;

    modport master (
        output mem_a,
        output mem_dout,
        output mem_wr,
        input  mem_din,
        input  io_buffer_full
    );

    modport slave (
        input  mem_a,
        input  mem_dout,
        input  mem_wr,
        output mem_din,
        output io_buffer_full
    );
endinterface

// File: rtl/mem_io_responder.sv
// Memory/IO responder: 128KB byte RAM plus an IO hub with UART TX/RX FIFOs,
// a free-running cycle counter with a tear-free snapshot, and a sticky program-stop flag.
module mem_io_responder #(
    parameter int ADDR_WIDTH    = 17,
    parameter int TX_FIFO_DEPTH = 8,
    parameter int RX_FIFO_DEPTH = 8
) (
    input  logic                clk_in,
    input  logic                rst_in,
    mem_io_responder_if.slave   bus,
    output logic                uart_tx_valid,
    output logic [7:0]          uart_tx_data,
    input  logic                uart_tx_ready,
    input  logic                uart_rx_valid,
    input  logic [7:0]          uart_rx_data,
    output logic                program_stop,
    output logic                tx_overflow
);

    localparam int TX_AW = $clog2(TX_FIFO_DEPTH);
    localparam int TX_PW = TX_AW + 1;
    localparam int RX_AW = $clog2(RX_FIFO_DEPTH);
    localparam int RX_PW = RX_AW + 1;

    localparam logic [17:0] IO_DATA = 18'h30000;
    localparam logic [17:0] IO_CNT0 = 18'h30004;
    localparam logic [17:0] IO_CNT1 = 18'h30005;
    localparam logic [17:0] IO_CNT2 = 18'h30006;
    localparam logic [17:0] IO_CNT3 = 18'h30007;

    logic [7:0]            ram [0:(1 << ADDR_WIDTH) - 1];
    logic [7:0]            tx_mem [0:TX_FIFO_DEPTH - 1];
    logic [7:0]            rx_mem [0:RX_FIFO_DEPTH - 1];

    logic [7:0]            mem_din_q, mem_din_d;
    logic [31:0]           cycle_cnt_q, cycle_cnt_d;
    logic [31:0]           snapshot_q, snapshot_d;
    logic                  program_stop_q, program_stop_d;
    logic                  tx_overflow_q, tx_overflow_d;
    logic [TX_PW-1:0]      tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
    logic [RX_PW-1:0]      rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;

    logic [17:0]           io_addr_s;
    logic                  is_io_s;
    logic [ADDR_WIDTH-1:0] ram_addr_s;
    logic                  ram_we_s;
    logic                  mem_a_unused;
    logic [TX_PW-1:0]      tx_count_s;
    logic                  tx_empty_s, tx_full_s;
    logic                  rx_empty_s, rx_full_s;
    logic                  tx_push_req_s, tx_push_ok_s, tx_pop_s;
    logic [7:0]            tx_push_data_s;
    logic                  rx_push_ok_s, rx_pop_s;
    logic [7:0]            rx_head_s;

    assign io_addr_s    = bus.mem_a[17:0];
    assign is_io_s      = (io_addr_s[17:16] == 2'b11);
    assign ram_addr_s   = bus.mem_a[ADDR_WIDTH-1:0];
    assign ram_we_s     = bus.mem_wr && !is_io_s;
    assign mem_a_unused = ^bus.mem_a[31:18];

    // Full when the wrap bits differ and the index bits match.
    assign tx_count_s = tx_wr_ptr_q - tx_rd_ptr_q;
    assign tx_empty_s = (tx_wr_ptr_q == tx_rd_ptr_q);
    assign tx_full_s  = (tx_wr_ptr_q[TX_AW] != tx_rd_ptr_q[TX_AW]) &&
                        (tx_wr_ptr_q[TX_AW-1:0] == tx_rd_ptr_q[TX_AW-1:0]);
    assign rx_empty_s = (rx_wr_ptr_q == rx_rd_ptr_q);
    assign rx_full_s  = (rx_wr_ptr_q[RX_AW] != rx_rd_ptr_q[RX_AW]) &&
                        (rx_wr_ptr_q[RX_AW-1:0] == rx_rd_ptr_q[RX_AW-1:0]);
    assign rx_head_s  = rx_mem[rx_rd_ptr_q[RX_AW-1:0]];

    assign tx_pop_s     = !tx_empty_s && uart_tx_ready;
    assign tx_push_ok_s = tx_push_req_s && (!tx_full_s || tx_pop_s);
    assign rx_pop_s     = !bus.mem_wr && (io_addr_s == IO_DATA) && !rx_empty_s;
    assign rx_push_ok_s = uart_rx_valid && (!rx_full_s || rx_pop_s);

    // One slot of slack so a cpu already committed to a write still fits.
    assign bus.io_buffer_full = (tx_count_s >= TX_PW'(TX_FIFO_DEPTH - 1));
    assign bus.mem_din        = mem_din_q;
    assign uart_tx_valid      = !tx_empty_s;
    assign uart_tx_data       = tx_mem[tx_rd_ptr_q[TX_AW-1:0]];
    assign program_stop       = program_stop_q;
    assign tx_overflow        = tx_overflow_q;

    // TX push request: data byte (zero is a no-op) or stop marker 0x00.
    always_comb begin
        tx_push_req_s  = 1'b0;
        tx_push_data_s = 8'h00;
        if (bus.mem_wr && (io_addr_s == IO_DATA)) begin
            tx_push_req_s  = (bus.mem_dout != 8'h00);
            tx_push_data_s = bus.mem_dout;
        end else if (bus.mem_wr && (io_addr_s == IO_CNT0)) begin
            tx_push_req_s  = 1'b1;
            tx_push_data_s = 8'h00;
        end else begin
            tx_push_req_s  = 1'b0;
            tx_push_data_s = 8'h00;
        end
    end

    // Next-state for read data, counter, snapshot, flags and FIFO pointers.
    always_comb begin
        mem_din_d      = mem_din_q;
        cycle_cnt_d    = cycle_cnt_q + 32'd1;
        snapshot_d     = snapshot_q;
        program_stop_d = program_stop_q;
        tx_overflow_d  = tx_overflow_q;
        tx_wr_ptr_d    = tx_wr_ptr_q;
        tx_rd_ptr_d    = tx_rd_ptr_q;
        rx_wr_ptr_d    = rx_wr_ptr_q;
        rx_rd_ptr_d    = rx_rd_ptr_q;

        if (bus.mem_wr) begin
            mem_din_d = mem_din_q;
        end else if (is_io_s) begin
            case (io_addr_s)
                IO_DATA: mem_din_d = rx_empty_s ? 8'h00 : rx_head_s;
                IO_CNT0: mem_din_d = cycle_cnt_q[7:0];
                IO_CNT1: mem_din_d = snapshot_q[15:8];
                IO_CNT2: mem_din_d = snapshot_q[23:16];
                IO_CNT3: mem_din_d = snapshot_q[31:24];
                default: mem_din_d = 8'h00;
            endcase
        end else begin
            mem_din_d = ram[ram_addr_s];
        end

        // Low byte is returned live; upper bytes come from this frozen copy.
        if (!bus.mem_wr && (io_addr_s == IO_CNT0)) begin
            snapshot_d = cycle_cnt_q;
        end else begin
            snapshot_d = snapshot_q;
        end

        if (bus.mem_wr && (io_addr_s == IO_CNT0)) begin
            program_stop_d = 1'b1;
        end else begin
            program_stop_d = program_stop_q;
        end

        if (tx_push_req_s && !tx_push_ok_s) begin
            tx_overflow_d = 1'b1;
        end else begin
            tx_overflow_d = tx_overflow_q;
        end

        if (tx_push_ok_s) begin
            tx_wr_ptr_d = tx_wr_ptr_q + TX_PW'(1);
        end else begin
            tx_wr_ptr_d = tx_wr_ptr_q;
        end
        if (tx_pop_s) begin
            tx_rd_ptr_d = tx_rd_ptr_q + TX_PW'(1);
        end else begin
            tx_rd_ptr_d = tx_rd_ptr_q;
        end
        if (rx_push_ok_s) begin
            rx_wr_ptr_d = rx_wr_ptr_q + RX_PW'(1);
        end else begin
            rx_wr_ptr_d = rx_wr_ptr_q;
        end
        if (rx_pop_s) begin
            rx_rd_ptr_d = rx_rd_ptr_q + RX_PW'(1);
        end else begin
            rx_rd_ptr_d = rx_rd_ptr_q;
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            mem_din_q      <= 8'h00;
            cycle_cnt_q    <= 32'd0;
            snapshot_q     <= 32'd0;
            program_stop_q <= 1'b0;
            tx_overflow_q  <= 1'b0;
            tx_wr_ptr_q    <= '0;
            tx_rd_ptr_q    <= '0;
            rx_wr_ptr_q    <= '0;
            rx_rd_ptr_q    <= '0;
        end else begin
            mem_din_q      <= mem_din_d;
            cycle_cnt_q    <= cycle_cnt_d;
            snapshot_q     <= snapshot_d;
            program_stop_q <= program_stop_d;
            tx_overflow_q  <= tx_overflow_d;
            tx_wr_ptr_q    <= tx_wr_ptr_d;
            tx_rd_ptr_q    <= tx_rd_ptr_d;
            rx_wr_ptr_q    <= rx_wr_ptr_d;
            rx_rd_ptr_q    <= rx_rd_ptr_d;
        end
    end

    // Storage arrays; contents survive reset, validity is tracked by the pointers.
    always_ff @(posedge clk_in) begin
        if (ram_we_s) begin
            ram[ram_addr_s] <= bus.mem_dout;
        end
        if (tx_push_ok_s) begin
            tx_mem[tx_wr_ptr_q[TX_AW-1:0]] <= tx_push_data_s;
        end
        if (rx_push_ok_s) begin
            rx_mem[rx_wr_ptr_q[RX_AW-1:0]] <= uart_rx_data;
        end
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed self-checking bench for mem_io_responder: RAM, cycle-counter snapshot,
// UART TX/RX FIFOs, program stop and reset behaviour, with hand-computed expectations.
module tb_mem_io_responder;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic       uart_tx_valid;
    logic [7:0] uart_tx_data;
    logic       uart_tx_ready;
    logic       uart_rx_valid;
    logic [7:0] uart_rx_data;
    logic       program_stop;
    logic       tx_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    mem_io_responder_if bus_if ();

    mem_io_responder #(
        .ADDR_WIDTH    (17),
        .TX_FIFO_DEPTH (8),
        .RX_FIFO_DEPTH (8)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .bus           (bus_if.slave),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_ready (uart_tx_ready),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_data  (uart_rx_data),
        .program_stop  (program_stop),
        .tx_overflow   (tx_overflow)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [7:0] d);
        bus_if.mem_a    = a;
        bus_if.mem_dout = d;
        bus_if.mem_wr   = 1'b1;
        step();
        bus_if.mem_wr   = 1'b0;
        bus_if.mem_a    = 32'h0000_0000;
        bus_if.mem_dout = 8'h00;
    endtask

    task automatic bus_rd(input logic [31:0] a);
        bus_if.mem_a  = a;
        bus_if.mem_wr = 1'b0;
        step();
        bus_if.mem_a  = 32'h0000_0000;
    endtask

    task automatic rx_push(input logic [7:0] d);
        uart_rx_valid = 1'b1;
        uart_rx_data  = d;
        step();
        uart_rx_valid = 1'b0;
        uart_rx_data  = 8'h00;
    endtask

    initial begin
        rst_in          = 1'b1;
        bus_if.mem_a    = 32'h0000_0000;
        bus_if.mem_dout = 8'h00;
        bus_if.mem_wr   = 1'b0;
        uart_tx_ready   = 1'b0;
        uart_rx_valid   = 1'b0;
        uart_rx_data    = 8'h00;

        step();
        step();
        chk("rst_mem_din",      {24'd0, bus_if.mem_din}, 32'h00);
        chk("rst_io_full",      {31'd0, bus_if.io_buffer_full}, 32'd0);
        chk("rst_tx_valid",     {31'd0, uart_tx_valid}, 32'd0);
        chk("rst_program_stop", {31'd0, program_stop}, 32'd0);
        chk("rst_tx_overflow",  {31'd0, tx_overflow}, 32'd0);
        rst_in = 1'b0;

        // Counter is 0 now; after 255 edges it reads 0xFF, carry lands on the next edge.
        repeat (255) step();
        bus_rd(32'h0003_0004);
        chk("cnt_b0",  {24'd0, bus_if.mem_din}, 32'hFF);
        bus_rd(32'h0003_0005);
        chk("cnt_b1",  {24'd0, bus_if.mem_din}, 32'h00);
        bus_rd(32'h0003_0006);
        chk("cnt_b2",  {24'd0, bus_if.mem_din}, 32'h00);
        bus_rd(32'h0003_0007);
        chk("cnt_b3",  {24'd0, bus_if.mem_din}, 32'h00);
        bus_rd(32'h0003_0004);
        chk("cnt2_b0", {24'd0, bus_if.mem_din}, 32'h03);
        bus_rd(32'h0003_0005);
        chk("cnt2_b1", {24'd0, bus_if.mem_din}, 32'h01);

        // RAM write then read back, top address and ignored upper address bits.
        bus_wr(32'h0000_0010, 8'hA5);
        bus_rd(32'h0000_0010);
        chk("ram_rd_10", {24'd0, bus_if.mem_din}, 32'hA5);
        bus_wr(32'h0001_FFFF, 8'h3C);
        bus_rd(32'h0001_FFFF);
        chk("ram_rd_top", {24'd0, bus_if.mem_din}, 32'h3C);
        bus_rd(32'hFFFC_0010);
        chk("ram_rd_alias", {24'd0, bus_if.mem_din}, 32'hA5);
        bus_rd(32'h0003_0010);
        chk("io_unmapped_rd", {24'd0, bus_if.mem_din}, 32'h00);

        // TX streaming with the UART always ready; a zero byte must not enqueue.
        uart_tx_ready = 1'b1;
        bus_wr(32'h0003_0000, 8'h48);
        chk("tx_h_valid", {31'd0, uart_tx_valid}, 32'd1);
        chk("tx_h_data",  {24'd0, uart_tx_data}, 32'h48);
        bus_wr(32'h0003_0000, 8'h69);
        chk("tx_i_data",  {24'd0, uart_tx_data}, 32'h69);
        bus_wr(32'h0003_0000, 8'h00);
        chk("tx_zero_dropped", {31'd0, uart_tx_valid}, 32'd0);
        bus_wr(32'h0003_0008, 8'h55);
        chk("io_unmapped_wr", {31'd0, uart_tx_valid}, 32'd0);

        // TX fill: nearly-full after 7, 8th fits, 9th overflows.
        uart_tx_ready = 1'b0;
        for (int i = 1; i <= 6; i++) bus_wr(32'h0003_0000, 8'(i));
        chk("tx_full_after6", {31'd0, bus_if.io_buffer_full}, 32'd0);
        bus_wr(32'h0003_0000, 8'h07);
        chk("tx_full_after7", {31'd0, bus_if.io_buffer_full}, 32'd1);
        bus_wr(32'h0003_0000, 8'h08);
        chk("tx_ovf_after8",  {31'd0, tx_overflow}, 32'd0);
        bus_wr(32'h0003_0000, 8'h09);
        chk("tx_ovf_after9",  {31'd0, tx_overflow}, 32'd1);
        uart_tx_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk("tx_drain_valid", {31'd0, uart_tx_valid}, 32'd1);
            chk("tx_drain_data",  {24'd0, uart_tx_data}, 32'(i));
            step();
        end
        chk("tx_drained_empty", {31'd0, uart_tx_valid}, 32'd0);
        chk("tx_drained_full",  {31'd0, bus_if.io_buffer_full}, 32'd0);
        chk("tx_ovf_sticky",    {31'd0, tx_overflow}, 32'd1);
        uart_tx_ready = 1'b0;

        // RX: one byte then empty read.
        rx_push(8'h31);
        bus_rd(32'h0003_0000);
        chk("rx_first",  {24'd0, bus_if.mem_din}, 32'h31);
        bus_rd(32'h0003_0000);
        chk("rx_empty",  {24'd0, bus_if.mem_din}, 32'h00);

        // RX: push and pop together on an empty FIFO keeps the new byte.
        uart_rx_valid = 1'b1;
        uart_rx_data  = 8'h77;
        bus_rd(32'h0003_0000);
        uart_rx_valid = 1'b0;
        chk("rx_sim_empty", {24'd0, bus_if.mem_din}, 32'h00);
        bus_rd(32'h0003_0000);
        chk("rx_sim_kept",  {24'd0, bus_if.mem_din}, 32'h77);

        // RX: ninth byte into a full FIFO is dropped.
        for (int i = 0; i <= 8; i++) rx_push(8'h40 + 8'(i));
        for (int i = 0; i < 8; i++) begin
            bus_rd(32'h0003_0000);
            chk("rx_full_seq", {24'd0, bus_if.mem_din}, 32'h40 + 32'(i));
        end
        bus_rd(32'h0003_0000);
        chk("rx_full_dropped", {24'd0, bus_if.mem_din}, 32'h00);

        // Program stop, then reset mid-operation.
        rx_push(8'h55);
        bus_wr(32'h0003_0004, 8'hAB);
        chk("stop_flag",     {31'd0, program_stop}, 32'd1);
        chk("stop_tx_valid", {31'd0, uart_tx_valid}, 32'd1);
        chk("stop_tx_data",  {24'd0, uart_tx_data}, 32'h00);
        bus_rd(32'h0000_0010);
        chk("pre_rst_rd", {24'd0, bus_if.mem_din}, 32'hA5);
        rst_in = 1'b1;
        bus_rd(32'h0000_0010);
        chk("rst2_mem_din", {24'd0, bus_if.mem_din}, 32'h00);
        chk("rst2_stop",    {31'd0, program_stop}, 32'd0);
        chk("rst2_tx_valid",{31'd0, uart_tx_valid}, 32'd0);
        chk("rst2_ovf",     {31'd0, tx_overflow}, 32'd0);
        rst_in = 1'b0;
        bus_rd(32'h0003_0000);
        chk("rst2_rx_empty", {24'd0, bus_if.mem_din}, 32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
